mem_port_arbiter: RTL and testbench

- Shares the single Ram port between the instruction-fetch requester and the load/store data requester of the multi-cycle RISC-V control.
- Accepts one access at a time, drives the Ram address/write bus for MEM_LATENCY cycles, then returns read data with a one-cycle valid pulse.
- Ties are resolved round-robin, or with fixed data priority when compiled in.

---
 rtl/mem_port_arbiter.sv | 155 +++++++++++++++
 tb/tb_mem_port_arbiter.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Shares one Ram port between instruction fetch and load/store data, one access at a time.
// Define MEM_PORT_ARBITER_DATA_PRIO_EN to make data win every tie instead of round-robin.
module mem_port_arbiter #(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int MEM_LATENCY = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [DATA_W-1:0] d_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy,
  output logic              last_owner
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  localparam logic [2:0] CNT_LAST = 3'(MEM_LATENCY - 1);

  state_t            state_q;
  logic              owner_q;
  logic              we_q;
  logic [2:0]        cnt_q;
  logic              if_gnt_q;
  logic              d_gnt_q;
  logic              if_rvalid_q;
  logic              d_rvalid_q;
  logic [DATA_W-1:0] if_rdata_q;
  logic [DATA_W-1:0] d_rdata_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic              mem_we_q;
  logic [DATA_W-1:0] mem_wdata_q;
  logic              busy_q;
  logic              last_owner_q;

  logic              any_req_s;
  logic              sel_data_s;
  logic              tie_data_s;

`ifdef MEM_PORT_ARBITER_DATA_PRIO_EN
  assign tie_data_s = 1'b1;
`else
  assign tie_data_s = ~last_owner_q;
`endif

  // Winner selection for the next grant; the owner of the last grant loses a tie.
  always_comb begin
    any_req_s  = if_req | d_req;
    sel_data_s = 1'b0;
    if (if_req && d_req) begin
      sel_data_s = tie_data_s;
    end else begin
      sel_data_s = d_req;
    end
  end

  // Access sequencer; the mem bus registers double as the latched request.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      owner_q      <= 1'b0;
      we_q         <= 1'b0;
      cnt_q        <= 3'd0;
      if_gnt_q     <= 1'b0;
      d_gnt_q      <= 1'b0;
      if_rvalid_q  <= 1'b0;
      d_rvalid_q   <= 1'b0;
      if_rdata_q   <= '0;
      d_rdata_q    <= '0;
      mem_addr_q   <= '0;
      mem_we_q     <= 1'b0;
      mem_wdata_q  <= '0;
      busy_q       <= 1'b0;
      last_owner_q <= 1'b1;
    end else begin
      case (state_q)
        IDLE, RESP: begin
          if_rvalid_q <= 1'b0;
          d_rvalid_q  <= 1'b0;
          if (any_req_s) begin
            state_q      <= ACCESS;
            owner_q      <= sel_data_s;
            last_owner_q <= sel_data_s;
            we_q         <= sel_data_s & d_we;
            cnt_q        <= 3'd0;
            if_gnt_q     <= ~sel_data_s;
            d_gnt_q      <= sel_data_s;
            mem_addr_q   <= sel_data_s ? d_addr : if_addr;
            mem_we_q     <= sel_data_s & d_we;
            mem_wdata_q  <= sel_data_s ? d_wdata : '0;
            busy_q       <= 1'b1;
          end else begin
            state_q <= IDLE;
          end
        end
        ACCESS: begin
          if_gnt_q <= 1'b0;
          d_gnt_q  <= 1'b0;
          mem_we_q <= 1'b0;
          if (cnt_q == CNT_LAST) begin
            if (!we_q) begin
              if (owner_q) begin
                d_rdata_q <= mem_rdata;
              end else begin
                if_rdata_q <= mem_rdata;
              end
            end
            if_rvalid_q <= ~owner_q;
            d_rvalid_q  <= owner_q;
            state_q     <= RESP;
            busy_q      <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
          end else begin
            cnt_q <= cnt_q + 3'd1;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign if_gnt     = if_gnt_q;
  assign if_rvalid  = if_rvalid_q;
  assign if_rdata   = if_rdata_q;
  assign d_gnt      = d_gnt_q;
  assign d_rvalid   = d_rvalid_q;
  assign d_rdata    = d_rdata_q;
  assign mem_addr   = mem_addr_q;
  assign mem_we     = mem_we_q;
  assign mem_wdata  = mem_wdata_q;
  assign busy       = busy_q;
  assign last_owner = last_owner_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: vector table on a MEM_LATENCY=1 instance,
// hand-written multi-cycle sequences on a MEM_LATENCY=3 instance.
module tb_mem_port_arbiter;

  typedef struct packed {
    logic        if_gnt;
    logic        if_rvalid;
    logic [31:0] if_rdata;
    logic        d_gnt;
    logic        d_rvalid;
    logic [31:0] d_rdata;
    logic [31:0] mem_addr;
    logic        mem_we;
    logic [31:0] mem_wdata;
    logic        busy;
    logic        last_owner;
  } outs_t;

  typedef struct {
    logic        if_req;
    logic [31:0] if_addr;
    logic        d_req;
    logic        d_we;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    outs_t       exp;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic if_req, d_req, d_we;
  logic [31:0] if_addr, d_addr, d_wdata;

  logic if_gnt1, if_rvalid1, d_gnt1, d_rvalid1, mem_we1, busy1, lo1;
  logic [31:0] if_rdata1, d_rdata1, mem_addr1, mem_wdata1, mem_rdata1;
  logic if_gnt3, if_rvalid3, d_gnt3, d_rvalid3, mem_we3, busy3, lo3;
  logic [31:0] if_rdata3, d_rdata3, mem_addr3, mem_wdata3, mem_rdata3;

  logic [31:0] ram1 [0:1023];
  logic [31:0] ram3 [0:1023];
  outs_t o1;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LATENCY(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt1), .if_rvalid(if_rvalid1), .if_rdata(if_rdata1),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt1), .d_rvalid(d_rvalid1), .d_rdata(d_rdata1),
    .mem_addr(mem_addr1), .mem_we(mem_we1), .mem_wdata(mem_wdata1), .mem_rdata(mem_rdata1),
    .busy(busy1), .last_owner(lo1)
  );

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LATENCY(3)) u_dut3 (
    .clk(clk), .rst_n(rst_n),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt3), .if_rvalid(if_rvalid3), .if_rdata(if_rdata3),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt3), .d_rvalid(d_rvalid3), .d_rdata(d_rdata3),
    .mem_addr(mem_addr3), .mem_we(mem_we3), .mem_wdata(mem_wdata3), .mem_rdata(mem_rdata3),
    .busy(busy3), .last_owner(lo3)
  );

  assign mem_rdata1 = ram1[mem_addr1[9:0]];
  assign mem_rdata3 = ram3[mem_addr3[9:0]];
  assign o1 = {if_gnt1, if_rvalid1, if_rdata1, d_gnt1, d_rvalid1, d_rdata1,
               mem_addr1, mem_we1, mem_wdata1, busy1, lo1};

  // Ram models: combinational read, write on the clock edge.
  initial begin
    for (int i = 0; i < 1024; i++) begin
      ram1[i] = 32'h0;
      ram3[i] = 32'h0;
    end
    ram1[10'h100] = 32'h00500293;
    ram1[10'h0FF] = 32'h11111111;
    ram1[10'h103] = 32'h22222222;
    ram1[10'h040] = 32'hDEADBEEF;
    ram3[10'h040] = 32'hDEADBEEF;
    forever begin
      @(posedge clk);
      if (mem_we1) ram1[mem_addr1[9:0]] = mem_wdata1;
      if (mem_we3) ram3[mem_addr3[9:0]] = mem_wdata3;
    end
  end

  function automatic outs_t mk(input logic ig, input logic ir, input logic [31:0] ird,
                               input logic dg, input logic dr, input logic [31:0] drd,
                               input logic [31:0] ma, input logic mw, input logic [31:0] mwd,
                               input logic b, input logic lo);
    outs_t o;
    o.if_gnt = ig;   o.if_rvalid = ir; o.if_rdata = ird;
    o.d_gnt = dg;    o.d_rvalid = dr;  o.d_rdata = drd;
    o.mem_addr = ma; o.mem_we = mw;    o.mem_wdata = mwd;
    o.busy = b;      o.last_owner = lo;
    return o;
  endfunction

  function automatic vec_t vc(input logic ir, input logic [31:0] ia, input logic dr,
                              input logic dw, input logic [31:0] da, input logic [31:0] dd,
                              input outs_t e);
    vec_t v;
    v.if_req = ir; v.if_addr = ia; v.d_req = dr; v.d_we = dw;
    v.d_addr = da; v.d_wdata = dd; v.exp = e;
    return v;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_o(input string name, input outs_t act, input outs_t exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic clear_inputs();
    if_req = 1'b0; if_addr = 32'h0;
    d_req = 1'b0; d_we = 1'b0; d_addr = 32'h0; d_wdata = 32'h0;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    step();
  endtask

  // One data access on the latency-3 instance; request dropped once granted.
  task automatic access3(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                         output int gnt_at, output int rv_at, output int rv_cnt,
                         output int we_cnt, output int busy_cnt,
                         output logic [31:0] rd, output logic [31:0] addr2);
    gnt_at = 0; rv_at = 0; rv_cnt = 0; we_cnt = 0; busy_cnt = 0; rd = 32'h0; addr2 = 32'h0;
    d_req = 1'b1; d_we = we; d_addr = addr; d_wdata = wd;
    for (int c = 1; c <= 8; c++) begin
      step();
      if (d_gnt3 && gnt_at == 0) gnt_at = c;
      if (d_gnt3) begin
        d_req = 1'b0; d_we = 1'b0; d_addr = 32'h0; d_wdata = 32'h0;
      end
      if (mem_we3) we_cnt++;
      if (busy3) busy_cnt++;
      if (c == 2) addr2 = mem_addr3;
      if (d_rvalid3) begin
        rv_cnt++;
        if (rv_at == 0) begin
          rv_at = c;
          rd = d_rdata3;
        end
      end
    end
  endtask

  localparam int NV = 16;
  vec_t vecs [NV];

  initial begin
    int ga, ra, rc, wc, bc, ng;
    logic [31:0] rd, a2;
    logic exp_d;

    vecs[0]  = vc(0, 32'h0,   0, 0, 32'h0,  32'h0,    mk(0,0,32'h0,       0,0,32'h0,       32'h0,  0,32'h0,   0,1));
    vecs[1]  = vc(1, 32'h100, 0, 0, 32'h0,  32'h0,    mk(1,0,32'h0,       0,0,32'h0,       32'h100,0,32'h0,   1,0));
    vecs[2]  = vc(0, 32'h0,   0, 0, 32'h0,  32'h0,    mk(0,1,32'h00500293,0,0,32'h0,       32'h0,  0,32'h0,   0,0));
    vecs[3]  = vc(0, 32'h0,   0, 0, 32'h0,  32'h0,    mk(0,0,32'h00500293,0,0,32'h0,       32'h0,  0,32'h0,   0,0));
    vecs[4]  = vc(1, 32'hFF,  0, 0, 32'h0,  32'h0,    mk(1,0,32'h00500293,0,0,32'h0,       32'hFF, 0,32'h0,   1,0));
    vecs[5]  = vc(0, 32'h0,   0, 0, 32'h0,  32'h0,    mk(0,1,32'h11111111,0,0,32'h0,       32'h0,  0,32'h0,   0,0));
    vecs[6]  = vc(1, 32'h103, 0, 0, 32'h0,  32'h0,    mk(1,0,32'h11111111,0,0,32'h0,       32'h103,0,32'h0,   1,0));
    vecs[7]  = vc(0, 32'h0,   0, 0, 32'h0,  32'h0,    mk(0,1,32'h22222222,0,0,32'h0,       32'h0,  0,32'h0,   0,0));
    vecs[8]  = vc(0, 32'h0,   1, 0, 32'h40, 32'h0,    mk(0,0,32'h22222222,1,0,32'h0,       32'h40, 0,32'h0,   1,1));
    vecs[9]  = vc(0, 32'h0,   0, 0, 32'h0,  32'h0,    mk(0,0,32'h22222222,0,1,32'hDEADBEEF,32'h0,  0,32'h0,   0,1));
    vecs[10] = vc(0, 32'h0,   1, 1, 32'h44, 32'h1234, mk(0,0,32'h22222222,1,0,32'hDEADBEEF,32'h44, 1,32'h1234,1,1));
    vecs[11] = vc(0, 32'h0,   0, 0, 32'h0,  32'h0,    mk(0,0,32'h22222222,0,1,32'hDEADBEEF,32'h0,  0,32'h0,   0,1));
    vecs[12] = vc(0, 32'h0,   1, 0, 32'h44, 32'h0,    mk(0,0,32'h22222222,1,0,32'hDEADBEEF,32'h44, 0,32'h0,   1,1));
    vecs[13] = vc(0, 32'h0,   0, 0, 32'h0,  32'h0,    mk(0,0,32'h22222222,0,1,32'h1234,    32'h0,  0,32'h0,   0,1));
    vecs[14] = vc(1, 32'h103, 0, 0, 32'h0,  32'h0,    mk(1,0,32'h22222222,0,0,32'h1234,    32'h103,0,32'h0,   1,0));
    vecs[15] = vc(0, 32'h0,   0, 0, 32'h0,  32'h0,    mk(0,1,32'h22222222,0,0,32'h1234,    32'h0,  0,32'h0,   0,0));

    // Reset values, checked while rst_n is still low.
    clear_inputs();
    repeat (2) @(negedge clk);
    chk_o("rst_u1", o1, mk(0,0,32'h0,0,0,32'h0,32'h0,0,32'h0,0,1));
    chk("rst_u3", 64'({if_gnt3, if_rvalid3, d_gnt3, d_rvalid3, mem_we3, busy3, lo3, mem_addr3}),
        64'({6'b0, 1'b1, 32'h0}));
    rst_n = 1'b1;
    step();

    for (int i = 0; i < NV; i++) begin
      if_req = vecs[i].if_req; if_addr = vecs[i].if_addr;
      d_req = vecs[i].d_req;   d_we = vecs[i].d_we;
      d_addr = vecs[i].d_addr; d_wdata = vecs[i].d_wdata;
      step();
      chk_o($sformatf("vec%0d", i), o1, vecs[i].exp);
    end

    // Both requesters held high on the latency-1 instance.
    do_reset();
    if_req = 1'b1; if_addr = 32'h100; d_req = 1'b1; d_we = 1'b0; d_addr = 32'h40;
    ng = 0;
    for (int c = 0; c < 40 && ng < 4; c++) begin
      step();
      if (if_gnt1 || d_gnt1) begin
`ifdef MEM_PORT_ARBITER_DATA_PRIO_EN
        exp_d = 1'b1;
`else
        exp_d = (ng % 2 == 1);
`endif
        chk($sformatf("tie_gnt%0d", ng), 64'({d_gnt1, if_gnt1, lo1}), 64'({exp_d, ~exp_d, exp_d}));
        ng++;
      end
    end
    chk("tie_count", 64'(ng), 64'd4);

    // Store then load at latency 3.
    do_reset();
    access3(1'b1, 32'h80, 32'h58, ga, ra, rc, wc, bc, rd, a2);
    chk("st_gnt_at", 64'(ga), 64'd1);
    chk("st_rvalid_at", 64'(ra), 64'd4);
    chk("st_rvalid_cnt", 64'(rc), 64'd1);
    chk("st_we_cnt", 64'(wc), 64'd1);
    chk("st_busy_cnt", 64'(bc), 64'd3);
    chk("st_addr_held", 64'(a2), 64'h80);
    chk("st_rdata_unchanged", 64'(rd), 64'h0);
    access3(1'b0, 32'h80, 32'h0, ga, ra, rc, wc, bc, rd, a2);
    chk("ld_rvalid_at", 64'(ra), 64'd4);
    chk("ld_we_cnt", 64'(wc), 64'd0);
    chk("ld_rdata", 64'(rd), 64'h58);

    // Reset during the second ACCESS cycle of a store.
    do_reset();
    access3(1'b0, 32'h40, 32'h0, ga, ra, rc, wc, bc, rd, a2);
    chk("pre_ld_rdata", 64'(rd), 64'hDEADBEEF);
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h90; d_wdata = 32'h77;
    step();
    clear_inputs();
    step();
    chk("abort_pre_busy", 64'({busy3, mem_addr3}), 64'({1'b1, 32'h90}));
    rst_n = 1'b0;
    #1;
    chk("abort_now", 64'({mem_we3, busy3, d_rvalid3, mem_addr3}), 64'h0);
    chk("abort_rdata", 64'(d_rdata3), 64'h0);
    @(negedge clk);
    rst_n = 1'b1;
    rc = 0; bc = 0;
    for (int c = 0; c < 6; c++) begin
      step();
      if (d_rvalid3) rc++;
      if (busy3) bc++;
    end
    chk("abort_no_rvalid", 64'({rc, bc}), 64'h0);
    chk("abort_last_owner", 64'(lo3), 64'd1);

    // Reset while mem_we is high drops it at once.
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h94; d_wdata = 32'h99;
    step();
    chk("we_pre", 64'(mem_we3), 64'd1);
    rst_n = 1'b0;
    #1;
    chk("we_async_drop", 64'(mem_we3), 64'd0);
    clear_inputs();
    @(negedge clk);
    rst_n = 1'b1;

    // Quiet bus with no requests.
    do_reset();
    for (int c = 0; c < 10; c++) begin
      step();
      chk($sformatf("idle%0d", c),
          64'({if_gnt1, if_rvalid1, d_gnt1, d_rvalid1, busy1, mem_we1, |mem_addr1,
               if_gnt3, if_rvalid3, d_gnt3, d_rvalid3, busy3, mem_we3, |mem_addr3}),
          64'd0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
